i2c_slave_regs: RTL and testbench

- 7-bit-addressed I2C target (responder) with a 4-byte data window.
- Oversamples the bus on the system clock and detects START, repeated START and STOP.
- Receives up to 4 write bytes into a 32-bit word and returns a 32-bit word on read.
- Paired with the team's I2C initiator on the same board, and with its 4-byte, MSB-first transfer format.

---
 rtl/i2c_slave_regs_if.sv | 26 ++
 rtl/i2c_slave_regs.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regs_if.sv
// Bus-facing signal bundle for the I2C register target: pin levels, open-drain
// SDA control and the 32-bit read/write word handshake.
interface i2c_slave_regs_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [31:0] tx_data;
    logic        rd_req;
    logic [31:0] rx_data;
    logic [2:0]  rx_count;
    logic        rx_valid;
    logic        busy;
    logic [2:0]  istate;

    // The target samples the pins and read word, and drives everything else.
    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rd_req, rx_data, rx_count, rx_valid, busy, istate
    );

    // The bus initiator / host side: the mirror image of the target.
    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rd_req, rx_data, rx_count, rx_valid, busy, istate
    );
endinterface

// File: rtl/i2c_slave_regs.sv
// 7-bit-addressed I2C target with a 4-byte (32-bit, MSB-first) data window.
// SCL/SDA are oversampled on clk; START/STOP take priority over SCL edges.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic             clk,
    input  logic             rst,
    i2c_slave_regs_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        AACK   = 3'd2,
        WRITE  = 3'd3,
        WACK   = 3'd4,
        READ   = 3'd5,
        RACK   = 3'd6,
        IGNORE = 3'd7
    } state_t;

    // Synchronizer plus one delay stage for edge detection.
    logic scl_s1_q, scl_s2_q, scl_dly_q;
    logic sda_s1_q, sda_s2_q, sda_dly_q;

    // Protocol state and its next-state values.
    state_t      state_q, state_d;
    logic        sda_oe_q, sda_oe_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic        rw_q, rw_d;
    logic        wr_mode_q, wr_mode_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic [2:0]  rx_count_q, rx_count_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rd_req_q, rd_req_d;
    logic        busy_q, busy_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [1:0] rd_next_idx;
    logic [7:0] rd_byte, rd_next_byte;

    // Picks byte idx out of a word, byte 0 being the most significant.
    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // Pin synchronizers; reset to the idle-high bus level so release from
    // reset never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            scl_dly_q <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            sda_dly_q <= 1'b1;
        end else begin
            scl_s1_q  <= bus.scl_in;
            scl_s2_q  <= scl_s1_q;
            scl_dly_q <= scl_s2_q;
            sda_s1_q  <= bus.sda_in;
            sda_s2_q  <= sda_s1_q;
            sda_dly_q <= sda_s2_q;
        end
    end

    assign scl_rise  =  scl_s2_q & ~scl_dly_q;
    assign scl_fall  = ~scl_s2_q &  scl_dly_q;
    assign start_det =  scl_s2_q &  scl_dly_q &  sda_dly_q & ~sda_s2_q;
    assign stop_det  =  scl_s2_q &  scl_dly_q & ~sda_dly_q &  sda_s2_q;

    assign rd_next_idx  = (byte_idx_q[1:0] == 2'd3) ? 2'd0 : byte_idx_q[1:0] + 2'd1;
    assign rd_byte      = byte_of(tx_word_q, byte_idx_q[1:0]);
    assign rd_next_byte = byte_of(tx_word_q, rd_next_idx);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sda_oe_q   <= 1'b0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            byte_idx_q <= 3'd0;
            shadow_q   <= 32'd0;
            tx_word_q  <= 32'd0;
            rw_q       <= 1'b0;
            wr_mode_q  <= 1'b0;
            rx_data_q  <= 32'd0;
            rx_count_q <= 3'd0;
            rx_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sda_oe_q   <= sda_oe_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            shadow_q   <= shadow_d;
            tx_word_q  <= tx_word_d;
            rw_q       <= rw_d;
            wr_mode_q  <= wr_mode_d;
            rx_data_q  <= rx_data_d;
            rx_count_q <= rx_count_d;
            rx_valid_q <= rx_valid_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: bus conditions first, then per-state SCL edge handling.
    always_comb begin
        state_d    = state_q;
        sda_oe_d   = sda_oe_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        shadow_d   = shadow_q;
        tx_word_d  = tx_word_q;
        rw_d       = rw_q;
        wr_mode_d  = wr_mode_q;
        rx_data_d  = rx_data_q;
        rx_count_d = rx_count_q;
        rx_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        busy_d     = busy_q;

        if (start_det || stop_det) begin
            // A write that delivered at least one byte is reported when the
            // transfer ends, whether by STOP or by a repeated START.
            if (state_q != IDLE && wr_mode_q && byte_idx_q != 3'd0) begin
                rx_data_d  = shadow_q;
                rx_count_d = byte_idx_q;
                rx_valid_d = 1'b1;
            end
            sda_oe_d   = 1'b0;
            wr_mode_d  = 1'b0;
            byte_idx_d = 3'd0;
            bit_cnt_d  = 4'd0;
            if (start_det) begin
                state_d = ADDR;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            rw_d       = shift_q[0];
                            shadow_d   = 32'd0;
                            byte_idx_d = 3'd0;
                            sda_oe_d   = 1'b1;
                            state_d    = AACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end
                    end
                end
                AACK: begin
                    if (scl_fall) begin
                        if (!rw_q) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            wr_mode_d = 1'b1;
                            state_d   = WRITE;
                        end else begin
                            // Read word is captured once per read address.
                            tx_word_d  = bus.tx_data;
                            rd_req_d   = 1'b1;
                            sda_oe_d   = ~bus.tx_data[31];
                            bit_cnt_d  = 4'd1;
                            byte_idx_d = 3'd0;
                            state_d    = READ;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (!byte_idx_q[2]) begin
                            case (byte_idx_q[1:0])
                                2'd0:    shadow_d[31:24] = shift_q;
                                2'd1:    shadow_d[23:16] = shift_q;
                                2'd2:    shadow_d[15:8]  = shift_q;
                                default: shadow_d[7:0]   = shift_q;
                            endcase
                            byte_idx_d = byte_idx_q + 3'd1;
                            sda_oe_d   = 1'b1;
                            state_d    = WACK;
                        end else begin
                            // Window full: refuse the extra byte.
                            sda_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end
                    end
                end
                WACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = RACK;
                        end else begin
                            sda_oe_d  = ~rd_byte[3'd7 - bit_cnt_q[2:0]];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise && sda_s2_q) begin
                        state_d = IGNORE;
                    end else if (scl_fall) begin
                        byte_idx_d = {1'b0, rd_next_idx};
                        sda_oe_d   = ~rd_next_byte[7];
                        bit_cnt_d  = 4'd1;
                        state_d    = READ;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rd_req   = rd_req_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_count = rx_count_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.istate   = state_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C initiator drives the
// pins, and immediate assertions check ACKs, read data and reported words.
module tb_i2c_slave_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [31:0] tx_word = 32'd0;

    int n_chk  = 0;
    int n_fail = 0;
    int rxv_cnt = 0;
    int rdq_cnt = 0;
    int oe_cnt  = 0;

    i2c_slave_regs_if bus ();

    // Open-drain line: the target pulls low when sda_oe is set.
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_m & ~bus.sda_oe;
    assign bus.tx_data = tx_word;

    i2c_slave_regs #(.SLAVE_ADDR(7'h50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse / activity counters, read as deltas by the checks.
    always @(posedge clk) begin
        if (bus.rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (bus.rd_req)   rdq_cnt <= rdq_cnt + 1;
        if (bus.sda_oe)   oe_cnt  <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Quarter SCL period = 4 clk; SCL period = 16 clk.
    task automatic wait_q();
        repeat (4) @(posedge clk);
        #2;
    endtask

    // One SCL clock: set SDA in the low phase, sample the line mid-high.
    task automatic bit_cycle(input logic drive, output logic sampled);
        wait_q(); sda_m = drive;
        wait_q(); scl_m = 1'b1;
        wait_q(); sampled = bus.sda_in;
        wait_q(); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q(); wait_q(); sda_m = 1'b0;
        wait_q(); wait_q(); scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_m = 1'b1;
        wait_q(); wait_q(); sda_m = 1'b0;
        wait_q(); wait_q(); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b1;
        wait_q(); wait_q(); sda_m = 1'b1;
        wait_q(); wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        acked = ~s;
        $display("wr byte 0x%02h ack=%0d", b, acked);
    endtask

    task automatic read_byte(input logic master_nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(master_nack, s);
        $display("rd byte 0x%02h nack=%0d", d, master_nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         base_rxv, base_rdq, base_oe;
        logic [7:0] wr4 [4];
        logic [7:0] rd4 [4];

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sda_oe",   {31'd0, bus.sda_oe},   32'd0);
        chk("rst_istate",   {29'd0, bus.istate},   32'd0);
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_rx_data",  bus.rx_data,           32'd0);
        chk("rst_rx_count", {29'd0, bus.rx_count}, 32'd0);
        rst = 1'b1;
        wait_q();

        // ---------------- 4-byte write ----------------
        wr4[0] = 8'hDE; wr4[1] = 8'hAD; wr4[2] = 8'hBE; wr4[3] = 8'hEF;
        base_rxv = rxv_cnt;
        i2c_start();
        chk("w4_busy", {31'd0, bus.busy}, 32'd1);
        write_byte(8'hA0, ack);
        chk("w4_addr_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            write_byte(wr4[i], ack);
            chk("w4_data_ack", {31'd0, ack}, 32'd1);
        end
        i2c_stop();
        chk("w4_rxv_pulses", rxv_cnt - base_rxv, 32'd1);
        chk("w4_rx_data",  bus.rx_data,           32'hDEADBEEF);
        chk("w4_rx_count", {29'd0, bus.rx_count}, 32'd4);
        chk("w4_busy_end", {31'd0, bus.busy},     32'd0);
        $display("txn write4 done rx_data=0x%08h", bus.rx_data);

        // ---------------- 4-byte read, NACK on last ----------------
        tx_word = 32'h12345678;
        rd4[0] = 8'h12; rd4[1] = 8'h34; rd4[2] = 8'h56; rd4[3] = 8'h78;
        base_rdq = rdq_cnt;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            read_byte(i == 3, d);
            chk("rd_byte", {24'd0, d}, {24'd0, rd4[i]});
        end
        chk("rd_ignore", {29'd0, bus.istate}, 32'd7);
        chk("rd_req_pulses", rdq_cnt - base_rdq, 32'd1);
        i2c_stop();
        chk("rd_idle", {29'd0, bus.istate}, 32'd0);
        $display("txn read4 done");

        // ---------------- wrong address ----------------
        base_oe  = oe_cnt;
        base_rxv = rxv_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        chk("na_addr_nack", {31'd0, ack}, 32'd0);
        write_byte(8'h33, ack);
        i2c_stop();
        chk("na_oe_never", oe_cnt - base_oe, 32'd0);
        chk("na_no_rxv", rxv_cnt - base_rxv, 32'd0);
        chk("na_busy", {31'd0, bus.busy}, 32'd0);
        $display("txn wrong-address done");

        // ---------------- 2-byte write, repeated START, read ----------------
        base_rxv = rxv_cnt;
        base_rdq = rdq_cnt;
        tx_word  = 32'hCAFEF00D;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        i2c_rstart();
        chk("rs_rxv", rxv_cnt - base_rxv, 32'd1);
        chk("rs_rx_data",  bus.rx_data,           32'h11220000);
        chk("rs_rx_count", {29'd0, bus.rx_count}, 32'd2);
        chk("rs_state_addr", {29'd0, bus.istate}, 32'd1);
        write_byte(8'hA1, ack);
        chk("rs_rd_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b1, d);
        chk("rs_rd_byte", {24'd0, d}, 32'h000000CA);
        i2c_stop();
        chk("rs_rdq", rdq_cnt - base_rdq, 32'd1);
        chk("rs_rxv_total", rxv_cnt - base_rxv, 32'd1);
        $display("txn write2+rstart+read done");

        // ---------------- 5-byte write ----------------
        i2c_start();
        write_byte(8'hA0, ack);
        for (int i = 1; i <= 4; i++) begin
            write_byte(i[7:0], ack);
            chk("w5_ack", {31'd0, ack}, 32'd1);
        end
        write_byte(8'h05, ack);
        chk("w5_fifth_nack", {31'd0, ack}, 32'd0);
        chk("w5_ignore", {29'd0, bus.istate}, 32'd7);
        i2c_stop();
        chk("w5_rx_data",  bus.rx_data,           32'h01020304);
        chk("w5_rx_count", {29'd0, bus.rx_count}, 32'd4);
        $display("txn write5 done rx_data=0x%08h", bus.rx_data);

        // ---------------- reset during ACK of byte 2 ----------------
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h77, ack);
        for (int i = 7; i >= 0; i--) begin
            logic s;
            logic [7:0] b;
            b = 8'h88;
            bit_cycle(b[i], s);
        end
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_m = 1'b1;
        wait_q();
        chk("rs2_oe_before", {31'd0, bus.sda_oe}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rs2_oe_async",  {31'd0, bus.sda_oe}, 32'd0);
        chk("rs2_state",     {29'd0, bus.istate}, 32'd0);
        chk("rs2_busy",      {31'd0, bus.busy},   32'd0);
        wait_q();
        rst = 1'b1;
        wait_q(); scl_m = 1'b0;
        i2c_stop();
        base_rxv = rxv_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("post_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h5A, ack);
        chk("post_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        chk("post_rxv", rxv_cnt - base_rxv, 32'd1);
        chk("post_rx_data",  bus.rx_data,           32'h5A000000);
        chk("post_rx_count", {29'd0, bus.rx_count}, 32'd1);
        $display("txn reset-recovery done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
